// File: rtl/irq_pkg.sv
// Shared definitions for the four-line interrupt controller: line count,
// vector layout, FSM state encoding and the vector address helper.
package irq_pkg;

    localparam int NUM_IRQ    = 4;
    localparam int IRQ_ID_W   = 2;
    localparam int VEC_W      = 10;
    localparam int VEC_STRIDE = 4;

    // Handler address of line 0; lines follow at VEC_STRIDE spacing.
    // The highest line (0x3F0 + 3*4 = 0x3FC) still fits in VEC_W bits.
    localparam logic [VEC_W-1:0] VEC_BASE = 10'h3F0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    // Handler address for a line index, truncated to the cpu PC width.
    function automatic logic [VEC_W-1:0] irq_vector(input logic [IRQ_ID_W-1:0] id);
        return VEC_W'(32'(VEC_BASE) + 32'(id) * 32'(VEC_STRIDE));
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Bundle of the request, cpu handshake and status signals between the
// interrupt controller (slave) and the cpu/system side (master).
interface irq_controller_if;

    logic [irq_pkg::NUM_IRQ-1:0]  req;
    logic                         mask_we;
    logic [irq_pkg::NUM_IRQ-1:0]  mask_in;
    logic                         ack;
    logic                         reti;
    logic                         irq;
    logic [irq_pkg::VEC_W-1:0]    vec;
    logic [irq_pkg::IRQ_ID_W-1:0] irq_id;
    logic [irq_pkg::NUM_IRQ-1:0]  pending;
    logic [irq_pkg::NUM_IRQ-1:0]  mask;

    // Controller side.
    modport slave (
        input  req, mask_we, mask_in, ack, reti,
        output irq, vec, irq_id, pending, mask
    );

    // Cpu / system side.
    modport master (
        output req, mask_we, mask_in, ack, reti,
        input  irq, vec, irq_id, pending, mask
    );

endinterface

// File: rtl/irq_edge_sync.sv
// Three-flop synchroniser for one asynchronous request line, followed by a
// rising-edge detector. A level held high yields a single one-cycle pulse.
module irq_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    output logic o_edge
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Shift the request through the synchroniser chain; r_s3 is the history tap.
    // NOTE: sequential state uses <= so every flop samples its pre-edge input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_req;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_edge = r_s2 & ~r_s3;

endmodule

// File: rtl/irq_controller.sv
// Four-line interrupt controller: edge-detects the request lines, latches
// pending requests, applies the cpu mask, picks the lowest-numbered eligible
// line and runs the irq/ack/reti handshake with one line in service at a time.
module irq_controller
    import irq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    irq_controller_if.slave    bus
);

    logic [NUM_IRQ-1:0]  w_edge;
    logic [NUM_IRQ-1:0]  w_eligible;
    logic [NUM_IRQ-1:0]  w_clear;
    logic [IRQ_ID_W-1:0] w_winner;
    logic                w_any;

    logic [NUM_IRQ-1:0]  r_mask;
    logic [NUM_IRQ-1:0]  r_pending;
    irq_state_e          r_state;
    logic                r_irq;
    logic [VEC_W-1:0]    r_vec;
    logic [IRQ_ID_W-1:0] r_irq_id;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        irq_edge_sync u_sync (
            .clk    (clk),
            .reset  (reset),
            .i_req  (bus.req[g]),
            .o_edge (w_edge[g])
        );
    end

    assign w_eligible = r_pending & r_mask;
    assign w_any      = |w_eligible;

    // Fixed-priority pick: scanning downwards lets line 0 overwrite the rest.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = IRQ_ID_W'(i);
            end
        end
    end

    // An accepted ack retires the pending bit of the latched line.
    always_comb begin
        w_clear = '0;
        if (r_state == ST_REQ && bus.ack) begin
            w_clear[r_irq_id] = 1'b1;
        end
    end

    // Mask register, loaded by the cpu write strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
        end else if (bus.mask_we) begin
            r_mask <= bus.mask_in;
        end
    end

    // Pending latches; a fresh edge on the line being acked keeps it pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | w_edge;
        end
    end

    // Request/service FSM with registered irq, vector and line index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_irq    <= 1'b0;
            r_vec    <= '0;
            r_irq_id <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state  <= ST_REQ;
                        r_irq    <= 1'b1;
                        r_irq_id <= w_winner;
                        r_vec    <= irq_vector(w_winner);
                    end
                end
                ST_REQ: begin
                    // Vector and index stay frozen: no pre-emption while waiting.
                    if (bus.ack) begin
                        r_state <= ST_SERVICE;
                        r_irq   <= 1'b0;
                    end else if (!w_eligible[r_irq_id]) begin
                        r_state <= ST_IDLE;
                        r_irq   <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (bus.reti) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_irq   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irq     = r_irq;
    assign bus.vec     = r_vec;
    assign bus.irq_id  = r_irq_id;
    assign bus.pending = r_pending;
    assign bus.mask    = r_mask;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller. A stimulus process drives the inputs
// each cycle, advances a behavioural model of the controller and queues the
// expected outputs; a monitor process compares the DUT after every clock edge.
module tb_irq_controller;

    typedef struct {
        bit       irq;
        bit [3:0] pend;
        bit [3:0] mask;
        bit [1:0] id;
        bit [9:0] vec;
    } snap_t;

    typedef struct {
        int       cyc;
        bit [1:0] id;
        bit [9:0] vec;
    } ev_t;

    logic clk = 1'b0;
    logic reset;

    irq_controller_if bus_if ();

    irq_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    snap_t snap_q[$];
    ev_t   ev_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    // Behavioural model state.
    int       m_phase;   // 0 = waiting for work, 1 = irq raised, 2 = in service
    int       m_line;
    bit       m_irq;
    bit [3:0] m_pend;
    bit [3:0] m_mask;
    bit [1:0] m_id;
    bit [9:0] m_vec;
    bit [3:0] m_hist[$]; // request values seen at successive clock edges
    int       stim_cyc = 0;
    bit [3:0] cur_req  = 4'b0;

    int       mon_cyc  = 0;
    logic     prev_irq = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, required 0x%0h", name, mon_cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the state after the next edge.
    task automatic step(input bit rst, input bit mwe, input bit [3:0] min,
                        input bit ack, input bit reti);
        bit [3:0] rising;
        bit [3:0] elig;
        bit [3:0] clr;
        int       n;
        reset          = rst;
        bus_if.req     = cur_req;
        bus_if.mask_we = mwe;
        bus_if.mask_in = min;
        bus_if.ack     = ack;
        bus_if.reti    = reti;
        if (rst) begin
            m_phase = 0;
            m_irq   = 1'b0;
            m_pend  = 4'b0;
            m_mask  = 4'b0;
            m_id    = 2'd0;
            m_vec   = 10'd0;
            m_hist  = {4'b0, 4'b0, 4'b0};
        end else begin
            n      = m_hist.size();
            // A request counts once it has been seen two edges ago but not three.
            rising = m_hist[n-2] & ~m_hist[n-3];
            elig   = m_pend & m_mask;
            clr    = 4'b0;
            case (m_phase)
                0: if (elig != 4'b0) begin
                    m_line = 0;
                    while (!elig[m_line]) m_line++;
                    m_phase = 1;
                    m_irq   = 1'b1;
                    m_id    = 2'(m_line);
                    m_vec   = 10'h3F0 + 10'(4 * m_line);
                    ev_q.push_back('{stim_cyc, m_id, m_vec});
                end
                1: if (ack) begin
                    clr[m_line] = 1'b1;
                    m_phase     = 2;
                    m_irq       = 1'b0;
                end else if (!elig[m_line]) begin
                    m_phase = 0;
                    m_irq   = 1'b0;
                end
                default: if (reti) m_phase = 0;
            endcase
            m_pend = (m_pend & ~clr) | rising;
            if (mwe) m_mask = min;
            m_hist.push_back(cur_req);
            if (m_hist.size() > 6) void'(m_hist.pop_front());
        end
        snap_q.push_back('{m_irq, m_pend, m_mask, m_id, m_vec});
        stim_cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    endtask

    task automatic run_until_model_irq(input int max_cycles);
        for (int i = 0; i < max_cycles && !m_irq; i++) step(1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    endtask

    task automatic do_ack();
        step(1'b0, 1'b0, 4'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reti();
        step(1'b0, 1'b0, 4'b0, 1'b0, 1'b1);
    endtask

    task automatic write_mask(input bit [3:0] value);
        step(1'b0, 1'b1, value, 1'b0, 1'b0);
    endtask

    // Monitor: compare every edge against the queued prediction.
    initial begin
        snap_t e;
        ev_t   v;
        forever begin
            @(posedge clk);
            #1;
            if (snap_q.size() > 0) begin
                e = snap_q.pop_front();
                check("irq",     32'(bus_if.irq),     32'(e.irq));
                check("pending", 32'(bus_if.pending), 32'(e.pend));
                check("mask",    32'(bus_if.mask),    32'(e.mask));
                check("irq_id",  32'(bus_if.irq_id),  32'(e.id));
                check("vec",     32'(bus_if.vec),     32'(e.vec));
                if (bus_if.irq === 1'b1 && prev_irq !== 1'b1) begin
                    if (ev_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL irq_event @cycle %0d: got irq for line %0d, required none",
                                 mon_cyc, bus_if.irq_id);
                    end else begin
                        v = ev_q.pop_front();
                        check("irq_rise_cycle", 32'(mon_cyc),       32'(v.cyc));
                        check("irq_rise_id",    32'(bus_if.irq_id), 32'(v.id));
                        check("irq_rise_vec",   32'(bus_if.vec),    32'(v.vec));
                    end
                end
                prev_irq = bus_if.irq;
            end
            mon_cyc++;
        end
    end

    initial begin
        m_hist = {4'b0, 4'b0, 4'b0};

        // Reset.
        step(1'b1, 1'b0, 4'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'b0, 1'b0, 1'b0);
        idle(2);
        // ack/reti while idle are ignored.
        step(1'b0, 1'b0, 4'b0, 1'b1, 1'b1);
        write_mask(4'hF);

        // Basic: line 2.
        cur_req = 4'b0100;
        run_until_model_irq(8);
        idle(2);
        do_ack();
        idle(2);
        do_reti();
        cur_req = 4'b0;
        idle(3);

        // Priority: lines 3 and 1 together.
        cur_req = 4'b1010;
        run_until_model_irq(8);
        do_ack();
        do_reti();
        run_until_model_irq(4);
        do_ack();
        idle(1);
        do_reti();
        cur_req = 4'b0;
        idle(3);

        // Masked line stays pending until enabled.
        write_mask(4'b1110);
        cur_req = 4'b0001;
        idle(6);
        write_mask(4'hF);
        run_until_model_irq(4);
        do_ack();
        do_reti();
        cur_req = 4'b0;
        idle(3);

        // Unmask race: line 1 masked while waiting for ack.
        cur_req = 4'b0010;
        run_until_model_irq(8);
        idle(1);
        write_mask(4'b1101);
        idle(3);
        write_mask(4'hF);
        run_until_model_irq(4);
        do_ack();
        do_reti();
        cur_req = 4'b0;
        idle(3);

        // Ack coinciding with a mask write that drops the line: ack wins.
        cur_req = 4'b0001;
        run_until_model_irq(8);
        step(1'b0, 1'b1, 4'b1110, 1'b1, 1'b0);
        idle(1);
        do_reti();
        write_mask(4'hF);
        cur_req = 4'b0;
        idle(3);

        // Set/clear collision on line 2.
        cur_req = 4'b0100;
        run_until_model_irq(8);
        cur_req = 4'b0;
        idle(3);
        cur_req = 4'b0100;
        idle(2);
        do_ack();
        idle(2);
        do_reti();
        run_until_model_irq(4);
        do_ack();
        do_reti();
        cur_req = 4'b0;
        idle(3);

        // Reset in the middle of a request.
        cur_req = 4'b1000;
        run_until_model_irq(8);
        idle(1);
        step(1'b1, 1'b0, 4'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'b0, 1'b0, 1'b0);
        idle(3);
        write_mask(4'hF);
        idle(4);
        cur_req = 4'b0;
        idle(4);

        // Randomised traffic.
        for (int c = 0; c < 800; c++) begin
            bit       rst;
            bit       mwe;
            bit [3:0] min;
            bit       ack;
            bit       reti;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(7) == 0) cur_req[b] = ~cur_req[b];
            end
            rst  = ($urandom_range(249) == 0);
            mwe  = ($urandom_range(19) == 0);
            min  = 4'($urandom | $urandom);
            ack  = (m_phase == 1 && $urandom_range(2) == 0) || ($urandom_range(15) == 0);
            reti = (m_phase == 2 && $urandom_range(3) == 0) || ($urandom_range(15) == 0);
            step(rst, mwe, min, ack, reti);
        end

        #1;
        check("leftover_irq_events", 32'(ev_q.size()), 32'd0);
        check("leftover_snapshots",  32'(snap_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
